// File: rtl/fft_pkg.sv
// Shared types and address helpers for the radix-2 DIT FFT butterfly address generator.
package fft_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } fsm_state_e;

  // Reverse the low n bits of value; bits at or above n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input logic [3:0] n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(n)) r[int'(n) - 1 - i] = value[i];
    end
    return r;
  endfunction

  // Insert a zero at bit position s of j: the upper-leg address of butterfly j.
  function automatic logic [31:0] ins_zero(input logic [31:0] j, input logic [3:0] s);
    logic [4:0] sh;
    sh = {1'b0, s} + 5'd1;
    return ((j >> s) << sh) | (j & ((32'd1 << s) - 32'd1));
  endfunction

endpackage

// File: rtl/fft_core_addr_gen_if.sv
// Controller-facing bundle of the butterfly address generator: stage request in, addresses out.
interface fft_core_addr_gen_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  ena_fft_core;
  logic [3:0]            stage_level;
  logic [3:0]            stage_number;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [ADDR_WIDTH-2:0] tw_addr;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] wr_addr_a;
  logic [ADDR_WIDTH-1:0] wr_addr_b;
  logic                  wr_en;
  logic                  stage_done;
  logic                  cfg_err;

  modport master (
    output ena_fft_core, stage_level, stage_number,
    input  rd_addr_a, rd_addr_b, tw_addr, rd_valid, wr_addr_a, wr_addr_b, wr_en,
    input  stage_done, cfg_err
  );

  modport slave (
    input  ena_fft_core, stage_level, stage_number,
    output rd_addr_a, rd_addr_b, tw_addr, rd_valid, wr_addr_a, wr_addr_b, wr_en,
    output stage_done, cfg_err
  );
endinterface

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b} from read issue to write issue.
module fft_addr_delay #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] a_q [DEPTH];
  logic [WIDTH-1:0] b_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      a_q[0]     <= in_a;
      b_q[0]     <= in_b;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
        a_q[i]     <= a_q[i-1];
        b_q[i]     <= b_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_a     = a_q[DEPTH-1];
  assign out_b     = b_q[DEPTH-1];

endmodule

// File: rtl/fft_core_addr_gen.sv
// Per-stage butterfly read/twiddle/write address generator for an in-place radix-2 DIT FFT.
// Optional ADDR_GEN_BITREV_EN: bit-reversed write addresses on the last stage.
module fft_core_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned BF_LATENCY = 7
) (
  input logic               clk,
  input logic               rst,
  fft_core_addr_gen_if.slave bus
);

  localparam int unsigned CntW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

  fsm_state_e            state_q;
  logic                  ena_q;
  logic [3:0]            s_q, n_q;
  logic [ADDR_WIDTH-2:0] j_q;
  logic [CntW-1:0]       drain_q;
  logic                  rd_valid_q, stage_done_q, cfg_err_q;
  logic [ADDR_WIDTH-1:0] rd_a_q, rd_b_q;
  logic [ADDR_WIDTH-2:0] tw_q;

  logic                  start, abort, cfg_ok;
  logic [31:0]           a32, b32, tw32, half32, last32, br_a, br_b;
  logic [ADDR_WIDTH-1:0] wr_in_a, wr_in_b;
  logic                  unused_bits;

  assign start  = bus.ena_fft_core & ~ena_q;
  // Controller dropping its enable mid-stage cancels the stage outright.
  assign abort  = ~bus.ena_fft_core & ((state_q == StRun) | (state_q == StDrain));
  assign cfg_ok = (bus.stage_number != 4'd0) && (32'(bus.stage_number) <= ADDR_WIDTH) &&
                  (bus.stage_level < bus.stage_number);

  always_comb begin
    half32  = 32'd1 << s_q;
    a32     = ins_zero(32'(j_q), s_q);
    b32     = a32 | half32;
    tw32    = (32'(j_q) & (half32 - 32'd1)) << (n_q - 4'd1 - s_q);
    last32  = (32'd1 << (n_q - 4'd1)) - 32'd1;
    br_a    = '0;
    br_b    = '0;
    wr_in_a = rd_a_q;
    wr_in_b = rd_b_q;
`ifdef ADDR_GEN_BITREV_EN
    br_a = bitrev(32'(rd_a_q), n_q);
    br_b = bitrev(32'(rd_b_q), n_q);
    if (s_q == n_q - 4'd1) begin
      wr_in_a = br_a[ADDR_WIDTH-1:0];
      wr_in_b = br_b[ADDR_WIDTH-1:0];
    end
`endif
  end

  assign unused_bits = ^{a32[31:ADDR_WIDTH], b32[31:ADDR_WIDTH], tw32[31:ADDR_WIDTH-1],
                         last32[31:ADDR_WIDTH-1], br_a[31:ADDR_WIDTH], br_b[31:ADDR_WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ena_q        <= 1'b0;
      s_q          <= '0;
      n_q          <= '0;
      j_q          <= '0;
      drain_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_a_q       <= '0;
      rd_b_q       <= '0;
      tw_q         <= '0;
      stage_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      ena_q        <= bus.ena_fft_core;
      rd_valid_q   <= 1'b0;
      stage_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            s_q <= bus.stage_level;
            n_q <= bus.stage_number;
            j_q <= '0;
            if (cfg_ok) begin
              cfg_err_q <= 1'b0;
              state_q   <= StRun;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            rd_valid_q <= 1'b1;
            rd_a_q     <= a32[ADDR_WIDTH-1:0];
            rd_b_q     <= b32[ADDR_WIDTH-1:0];
            tw_q       <= tw32[ADDR_WIDTH-2:0];
            if (j_q == last32[ADDR_WIDTH-2:0]) begin
              drain_q <= '0;
              state_q <= StDrain;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (drain_q == CntW'(BF_LATENCY - 1)) begin
            state_q <= StDone;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StDone: begin
          stage_done_q <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fft_addr_delay #(
    .WIDTH(ADDR_WIDTH),
    .DEPTH(BF_LATENCY)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .in_valid (rd_valid_q),
    .in_a     (wr_in_a),
    .in_b     (wr_in_b),
    .out_valid(bus.wr_en),
    .out_a    (bus.wr_addr_a),
    .out_b    (bus.wr_addr_b)
  );

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_addr_a  = rd_a_q;
  assign bus.rd_addr_b  = rd_b_q;
  assign bus.tw_addr    = tw_q;
  assign bus.stage_done = stage_done_q;
  assign bus.cfg_err    = cfg_err_q;

endmodule
